ospi_ctrl: RTL and testbench
============================

OSPI_CTRL -- requirements
Module: ospi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per OSPI_CLK half-period (legal 1..15).
REQ-002 SHALL have parameter DUMMY_CYCLES, default 4, meaning OSPI_CLK periods of read turnaround (legal 0..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  internal logic clock, rising edge.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: cmd_valid  in  1  host command request.
REQ-007 Port: cmd_ready  out  1  controller idle and able to accept a command.
REQ-008 Port: cmd_op  in  2  operation: 00 read, 01 write, 10 erase, 11 illegal.
REQ-009 Port: cmd_addr  in  8  flash byte address.
REQ-010 Port: cmd_wdata  in  8  write data.
REQ-011 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-012 Port: rsp_rdata  out  8  read data, valid with rsp_valid on a read.
REQ-013 Port: rsp_err  out  1  illegal-op flag, valid with rsp_valid.
REQ-014 Port: OSPI_CLK  out  1  serial clock to flash; idles low.
REQ-015 Port: OSPI_CS  out  1  chip select, active low.
REQ-016 Port: ospi_io_o / ospi_io_oe / ospi_io_i  out/out/in  8/1/8  octal bus drive, drive-enable and sample; the top level builds OSPI_IO0..7 tri-states from these.

Function
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a clk edge with cmd_valid&&cmd_ready, capturing op, addr and wdata.
REQ-018 FSM states SHALL be IDLE, CS_SETUP, CMD, ADDR, WDATA, DUMMY, RDATA, CS_HOLD and DONE.
REQ-019 Sequences: read = CMD, ADDR, DUMMY, RDATA; write = CMD, ADDR, WDATA; erase = CMD, ADDR. Each sequence SHALL start with CS_SETUP and end with CS_HOLD, then DONE.
REQ-020 CS_SETUP and CS_HOLD SHALL each last CLK_DIV clk cycles with OSPI_CS low and OSPI_CLK low.
REQ-021 CMD, ADDR, WDATA, RDATA and each dummy period SHALL last exactly one OSPI_CLK period: CLK_DIV cycles low, then CLK_DIV cycles high.
REQ-022 Opcode bytes on the bus during CMD SHALL be read 0x03, write 0x02, erase 0x20.
REQ-023 ospi_io_o SHALL change only while OSPI_CLK is low, so the flash samples it on the rising edge.
REQ-024 ospi_io_oe SHALL be 1 during CMD, ADDR and WDATA, and 0 at all other times.
REQ-025 In RDATA, the controller SHALL register ospi_io_i on the clk edge where OSPI_CLK rises.
REQ-026 In DONE, rsp_valid SHALL pulse for 1 cycle with OSPI_CS high; DONE SHALL then go to IDLE.
REQ-027 Latency with defaults (acceptance edge = cycle 0) SHALL be: rsp_valid at cycle 13 for erase, 17 for write, 33 for read.
REQ-028 rsp_rdata SHALL hold its value until the next read completes; write and erase SHALL NOT change it.
REQ-029 An illegal op SHALL be accepted, SHALL leave OSPI_CS high and OSPI_CLK idle, and SHALL pulse rsp_valid with rsp_err=1 on cycle 1.
REQ-030 cmd_valid raised while busy SHALL be ignored, with no queueing.
REQ-031 With DUMMY_CYCLES=0, the FSM SHALL go from ADDR directly to RDATA.

Reset
REQ-032 While reset is high, the FSM SHALL go to IDLE on the next clk edge, including mid-transaction.
REQ-033 Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0xFF, rsp_err=0, OSPI_CLK=0, OSPI_CS=1, ospi_io_oe=0, ospi_io_o=0x00.
REQ-034 A transaction aborted by reset SHALL produce no rsp_valid.

Configuration
REQ-035 With macro OSPI_CTRL_TXN_COUNT_EN defined, output txn_count[15:0] SHALL reset to 0 and increment, saturating at 0xFFFF, on each rsp_valid with rsp_err=0.
REQ-036 Without OSPI_CTRL_TXN_COUNT_EN, the txn_count port and its counter SHALL be absent.

Structure
REQ-037 Package ospi_pkg SHALL hold the op encoding typedef, opcode constants (0x03/0x02/0x20) and the FSM state typedef.
REQ-038 Sub-module ospi_clkgen SHALL implement the CLK_DIV divider, producing OSPI_CLK and single-cycle rise/fall strobes, enabled only outside IDLE/DONE.

Verification
REQ-039 Write op=01 addr=0x5A wdata=0xC3 with ospi_flash model attached -> bus carries 0x02, 0x5A, 0xC3 on three OSPI_CLK rises; rsp_valid at cycle 17 with rsp_err=0.
REQ-040 Read of addr 0x5A after the write -> bus carries 0x03, 0x5A; oe=0 for 4 dummy periods; rsp_rdata=0xC3 at cycle 33.
REQ-041 Erase addr 0x5A then read 0x5A -> erase completes at cycle 13; the following read returns 0xFF.
REQ-042 op=11 -> OSPI_CS stays high; rsp_valid with rsp_err=1 on cycle 1; cmd_ready=1 on cycle 2.
REQ-043 Reset asserted at cycle 10 of a read -> next edge gives OSPI_CS=1, oe=0, cmd_ready=1; no rsp_valid; a new read then completes correctly.
REQ-044 cmd_valid held high during a write -> exactly one transaction runs; a second starts only after DONE; with OSPI_CTRL_TXN_COUNT_EN, txn_count=2.

Source files
------------

// File: rtl/ospi_pkg.sv
// ---------------------------------------------------------------------------
// ospi_pkg
// Shared types and constants for the octal-SPI flash controller:
//   - ospi_op_e    : host operation encoding carried on cmd_op
//   - OPC_*        : flash opcode bytes driven during the CMD phase
//   - ospi_state_e : controller FSM states
//   - opcode_of()  : maps a host operation to its flash opcode byte
// ---------------------------------------------------------------------------
package ospi_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_ERASE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } ospi_op_e;

  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_ERASE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_DUMMY,
    ST_RDATA,
    ST_CS_HOLD,
    ST_DONE
  } ospi_state_e;

  function automatic logic [7:0] opcode_of(input ospi_op_e op);
    logic [7:0] opc;
    case (op)
      OP_READ:  opc = OPC_READ;
      OP_WRITE: opc = OPC_WRITE;
      OP_ERASE: opc = OPC_ERASE;
      default:  opc = 8'h00;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/ospi_clkgen.sv
// ---------------------------------------------------------------------------
// ospi_clkgen
// Divides clk down to the serial flash clock. Every CLK_DIV clk cycles a
// half-period "tick" is produced while enabled; when run is also high the
// serial clock toggles on each tick, giving one OSPI_CLK period of CLK_DIV
// cycles low followed by CLK_DIV cycles high.
//
// Parameters:
//   CLK_DIV  clk cycles per OSPI_CLK half-period (1..15)
// Ports:
//   clk       in   internal clock, rising edge
//   reset     in   synchronous active-high reset
//   en        in   divider enable; when low the counter and OSPI_CLK clear
//   run       in   allow OSPI_CLK to toggle (low keeps it parked low)
//   ospi_clk  out  serial clock, idles low
//   tick      out  single-cycle strobe at the end of each half-period
//   rise      out  single-cycle strobe: OSPI_CLK goes high at this edge
//   fall      out  single-cycle strobe: OSPI_CLK goes low at this edge
// ---------------------------------------------------------------------------
module ospi_clkgen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic run,
  output logic ospi_clk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_LAST = 4'(CLK_DIV - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       clk_q, clk_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    rise  = tick && run && !clk_q;
    fall  = tick && run && clk_q;
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (!en) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 4'd1;
      if (rise) begin
        clk_d = 1'b1;
      end else if (fall) begin
        clk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign ospi_clk = clk_q;

endmodule

// File: rtl/ospi_ctrl.sv
// ---------------------------------------------------------------------------
// ospi_ctrl
// Octal-SPI flash controller. Accepts one host command at a time (read,
// write, erase) and runs the matching flash bus sequence:
//   read  : CS_SETUP, CMD, ADDR, DUMMY x DUMMY_CYCLES, RDATA, CS_HOLD, DONE
//   write : CS_SETUP, CMD, ADDR, WDATA, CS_HOLD, DONE
//   erase : CS_SETUP, CMD, ADDR, CS_HOLD, DONE
// An illegal op goes straight to DONE and reports rsp_err without touching
// the flash bus.
//
// Parameters:
//   CLK_DIV       clk cycles per OSPI_CLK half-period (1..15)
//   DUMMY_CYCLES  OSPI_CLK periods of read turnaround (0..15)
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   cmd_valid/cmd_ready     host command handshake (ready only when idle)
//   cmd_op[1:0]             00 read, 01 write, 10 erase, 11 illegal
//   cmd_addr[7:0]           flash byte address
//   cmd_wdata[7:0]          write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata[7:0]          last completed read data (held across writes)
//   rsp_err                 illegal-op flag, qualified by rsp_valid
//   OSPI_CLK                serial clock, idles low
//   OSPI_CS                 chip select, active low
//   ospi_io_o/_oe/_i        octal bus drive, drive enable, sample
//   txn_count[15:0]         successful completions, saturating (only when
//                           OSPI_CTRL_TXN_COUNT_EN is defined)
// ---------------------------------------------------------------------------
module ospi_ctrl
  import ospi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        OSPI_CLK,
  output logic        OSPI_CS,
  output logic [7:0]  ospi_io_o,
  output logic        ospi_io_oe,
  input  logic [7:0]  ospi_io_i
`ifdef OSPI_CTRL_TXN_COUNT_EN
  ,
  output logic [15:0] txn_count
`endif
);

  localparam logic [3:0] DCNT_LAST = 4'(DUMMY_CYCLES - 1);

  ospi_state_e state_q, state_d;
  ospi_op_e    op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  io_o_q, io_o_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [3:0]  dcnt_q, dcnt_d;

  logic clk_en, clk_run;
  logic tick, rise, fall;

  ospi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk     (clk),
    .reset   (reset),
    .en      (clk_en),
    .run     (clk_run),
    .ospi_clk(OSPI_CLK),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall)
  );

  // Phase outputs decode directly from the state register so that a reset
  // edge releases CS and the bus in the same cycle the FSM returns to IDLE.
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_DONE);
    rsp_err    = (state_q == ST_DONE) && (op_q == OP_ILLEGAL);
    OSPI_CS    = !(state_q inside {ST_CS_SETUP, ST_CMD, ST_ADDR, ST_WDATA,
                                   ST_DUMMY, ST_RDATA, ST_CS_HOLD});
    ospi_io_oe = state_q inside {ST_CMD, ST_ADDR, ST_WDATA};
    clk_en     = !(state_q inside {ST_IDLE, ST_DONE});
    clk_run    = state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY, ST_RDATA};
  end

  // Bus phases advance on the falling strobe, so the next byte is loaded onto
  // ospi_io_o at the same edge OSPI_CLK drops and is stable for a full low
  // half-period before the flash samples it on the rise.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    io_o_d  = io_o_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    dcnt_d  = dcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = ospi_op_e'(cmd_op);
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = (ospi_op_e'(cmd_op) == OP_ILLEGAL) ? ST_DONE : ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (tick) begin
          io_o_d  = opcode_of(op_q);
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (fall) begin
          io_o_d  = addr_q;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (fall) begin
          case (op_q)
            OP_READ: begin
              dcnt_d  = '0;
              state_d = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
            end
            OP_WRITE: begin
              io_o_d  = wdata_q;
              state_d = ST_WDATA;
            end
            default: state_d = ST_CS_HOLD;
          endcase
        end
      end
      ST_WDATA: begin
        if (fall) begin
          state_d = ST_CS_HOLD;
        end
      end
      ST_DUMMY: begin
        if (fall) begin
          dcnt_d = dcnt_q + 4'd1;
          if (dcnt_q == DCNT_LAST) begin
            state_d = ST_RDATA;
          end
        end
      end
      ST_RDATA: begin
        if (rise) begin
          rx_d = ospi_io_i;
        end
        if (fall) begin
          state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          // Commit read data only on completion so rsp_rdata keeps the last
          // completed read until the next one finishes.
          if (op_q == OP_READ) begin
            rdata_d = rx_q;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      io_o_q  <= '0;
      rx_q    <= '1;
      rdata_q <= '1;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      io_o_q  <= io_o_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign ospi_io_o = io_o_q;
  assign rsp_rdata = rdata_q;

`ifdef OSPI_CTRL_TXN_COUNT_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (rsp_valid && !rsp_err && (txn_count_q != 16'hFFFF)) begin
      txn_count_d = txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txn_count_q <= '0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_ospi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ospi_ctrl
// Scoreboard bench for ospi_ctrl with a behavioural flash attached to the
// octal bus. Stimulus pushes expected responses (data, error flag, completion
// cycle) and expected per-rise bus contents into queues; independent monitor
// processes pop and compare whenever the DUT presents a response or the
// serial clock rises. Build with +define+OSPI_CTRL_TXN_COUNT_EN to also check
// the transaction counter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ospi_ctrl;

  localparam int CD = 2;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       OSPI_CLK;
  logic       OSPI_CS;
  logic [7:0] ospi_io_o;
  logic       ospi_io_oe;
  logic [7:0] ospi_io_i = 8'h00;
`ifdef OSPI_CTRL_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  always #5 clk = ~clk;

  ospi_ctrl #(
    .CLK_DIV(CD),
    .DUMMY_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .OSPI_CLK  (OSPI_CLK),
    .OSPI_CS   (OSPI_CS),
    .ospi_io_o (ospi_io_o),
    .ospi_io_oe(ospi_io_oe),
    .ospi_io_i (ospi_io_i)
`ifdef OSPI_CTRL_TXN_COUNT_EN
    ,
    .txn_count (txn_count)
`endif
  );

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  int rsp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  typedef struct {
    logic       oe;
    logic [7:0] b;
  } bus_t;

  exp_t       sb_q[$];
  bus_t       bus_q[$];
  logic [7:0] ref_mem[256];
  logic [7:0] ref_last = 8'hFF;
  int         ref_txn = 0;

  // Completion cycle counted from the acceptance edge.
  function automatic int latency(input logic [1:0] op);
    int half = CD;
    int per  = 2 * CD;
    case (op)
      2'b00:   return half + (3 + DC) * per + half + 1;
      2'b01:   return half + 3 * per + half + 1;
      2'b10:   return half + 2 * per + half + 1;
      default: return 1;
    endcase
  endfunction

  function automatic bus_t mk(input logic oe, input logic [7:0] b);
    bus_t x;
    x.oe = oe;
    x.b  = b;
    return x;
  endfunction

  task automatic push_expect(input logic [1:0] op, input logic [7:0] a,
                             input logic [7:0] d, input int acc);
    exp_t e;
    case (op)
      2'b00: begin
        ref_last = ref_mem[a];
        bus_q.push_back(mk(1'b1, 8'h03));
        bus_q.push_back(mk(1'b1, a));
        for (int k = 0; k < DC + 1; k++) bus_q.push_back(mk(1'b0, 8'h00));
      end
      2'b01: begin
        ref_mem[a] = d;
        bus_q.push_back(mk(1'b1, 8'h02));
        bus_q.push_back(mk(1'b1, a));
        bus_q.push_back(mk(1'b1, d));
      end
      2'b10: begin
        ref_mem[a] = 8'hFF;
        bus_q.push_back(mk(1'b1, 8'h20));
        bus_q.push_back(mk(1'b1, a));
      end
      default: ;
    endcase
    if (op != 2'b11) ref_txn++;
    e.cyc   = acc + latency(op) - 1;
    e.rdata = ref_last;
    e.err   = (op == 2'b11);
    sb_q.push_back(e);
  endtask

  // ---------------- behavioural flash ----------------
  logic [7:0] fl_mem[256];
  int         fl_rise = 0;
  logic [7:0] fl_op = 8'h00;
  logic [7:0] fl_addr = 8'h00;
  logic [7:0] fl_data = 8'h00;
  bus_t       bx;

  always @(posedge OSPI_CLK) begin
    if (!OSPI_CS) begin
      fl_rise++;
      if (fl_rise == 1) fl_op = ospi_io_o;
      else if (fl_rise == 2) fl_addr = ospi_io_o;
      else if (fl_rise == 3) fl_data = ospi_io_o;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_rise", bus_q.size(), 1);
      end else begin
        bx = bus_q.pop_front();
        chk("bus_oe", 32'(ospi_io_oe), 32'(bx.oe));
        if (bx.oe) chk("bus_byte", 32'(ospi_io_o), 32'(bx.b));
      end
    end
  end

  // Read data is presented only in the low half-period before the data rise;
  // every other time the flash drives noise.
  always @(negedge OSPI_CLK) begin
    if (!OSPI_CS && fl_op == 8'h03 && fl_rise == 2 + DC) ospi_io_i = fl_mem[fl_addr];
    else ospi_io_i = 8'($urandom);
  end

  always @(posedge OSPI_CS) begin
    if (fl_op == 8'h02 && fl_rise == 3) fl_mem[fl_addr] = fl_data;
    else if (fl_op == 8'h20 && fl_rise == 2) fl_mem[fl_addr] = 8'hFF;
    fl_rise = 0;
    fl_op   = 8'h00;
  end

  // ---------------- response monitor ----------------
  exp_t       me;
  logic [7:0] prev_io = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      if (ospi_io_o != prev_io) chk("io_o_change_clk_low", 32'(OSPI_CLK), 0);
      prev_io = ospi_io_o;
      if (rsp_valid) begin
        rsp_seen++;
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          me = sb_q.pop_front();
          chk("rsp_cycle", cyc, me.cyc);
          chk("rsp_err", 32'(rsp_err), 32'(me.err));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(me.rdata));
          chk("rsp_cs_high", 32'(OSPI_CS), 1);
        end
      end
    end else begin
      prev_io = ospi_io_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input bit abort, output int acc);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("issue_ready_timeout", 32'(cmd_ready), 1);
      acc = -1;
      return;
    end
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    acc = cyc + 1;
    if (abort) begin
      bus_q.push_back(mk(1'b1, 8'h03));
      bus_q.push_back(mk(1'b1, a));
    end else begin
      push_expect(op, a, d, acc);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || !cmd_ready) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0 || !cmd_ready) chk("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, a1, a2, g, seen0;
    logic [1:0] rop;
    logic [7:0] ra, rd;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'hFF;
      fl_mem[i]  = 8'hFF;
    end

    // Reset values.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_ospi_clk", 32'(OSPI_CLK), 0);
    chk("rst_ospi_cs", 32'(OSPI_CS), 1);
    chk("rst_io_oe", 32'(ospi_io_oe), 0);
    chk("rst_io_o", 32'(ospi_io_o), 0);
    reset = 1'b0;

    // cmd_valid held through a write: one transaction, the next only after DONE.
    @(negedge clk);
    cmd_op = 2'b01; cmd_addr = 8'h11; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
    a1 = cyc + 1;
    push_expect(2'b01, 8'h11, 8'h3C, a1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!cmd_ready && g < 100);
    a2 = cyc + 1;
    chk("held_second_accept", a2 - a1, 18);
    push_expect(2'b01, 8'h11, 8'h3C, a2);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();
`ifdef OSPI_CTRL_TXN_COUNT_EN
    chk("txn_count_held", 32'(txn_count), 2);
`endif

    // Write, read back, erase, read back.
    issue(2'b01, 8'h5A, 8'hC3, 1'b0, acc);
    issue(2'b00, 8'h5A, 8'h00, 1'b0, acc);
    issue(2'b10, 8'h5A, 8'h00, 1'b0, acc);
    issue(2'b00, 8'h5A, 8'h00, 1'b0, acc);
    drain();

    // Illegal op: bus untouched, response on cycle 1, ready on cycle 2.
    issue(2'b11, 8'h00, 8'h00, 1'b0, acc);
    chk("illegal_cs_high", 32'(OSPI_CS), 1);
    chk("illegal_clk_idle", 32'(OSPI_CLK), 0);
    chk("illegal_busy_cycle1", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("illegal_ready_cycle2", 32'(cmd_ready), 1);
    drain();

    // Reset at cycle 10 of a read.
    issue(2'b01, 8'h5A, 8'h77, 1'b0, acc);
    drain();
    seen0 = rsp_seen;
    issue(2'b00, 8'h5A, 8'h00, 1'b1, acc);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs_high", 32'(OSPI_CS), 1);
    chk("abort_oe_low", 32'(ospi_io_oe), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_clk_low", 32'(OSPI_CLK), 0);
    chk("abort_bus_consumed", bus_q.size(), 0);
    reset = 1'b0;
    ref_last = 8'hFF;
    ref_txn  = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_rsp", rsp_seen - seen0, 0);
    chk("abort_rdata_reset", 32'(rsp_rdata), 32'hFF);
    issue(2'b00, 8'h5A, 8'h00, 1'b0, acc);
    drain();

    // Random traffic over a small address set so reads hit earlier writes.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom_range(0, 7));
      rd  = 8'($urandom);
      issue(rop, ra, rd, 1'b0, acc);
    end
    drain();
    chk("bus_queue_empty", bus_q.size(), 0);
`ifdef OSPI_CTRL_TXN_COUNT_EN
    chk("txn_count_final", 32'(txn_count), ref_txn);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
